// File: rtl/vga_pkg.sv
// Shared VGA definitions: FSM states, window defaults, 640x480 timing and pixel type.
package vga_pkg;

  // 640x480 @ 60 Hz raster
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;

  // Default display window and scaling
  localparam int unsigned WIN_X0_DEF = 120;
  localparam int unsigned WIN_Y0_DEF = 40;
  localparam int unsigned WIN_W_DEF  = 400;
  localparam int unsigned WIN_H_DEF  = 400;
  localparam int unsigned SCALE_DEF  = 4;
  localparam int unsigned IMG_W_DEF  = WIN_W_DEF / SCALE_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StActive
  } state_e;

  typedef logic [23:0] rgb888_t;

endpackage

// File: rtl/delay_line.sv
// Strobe-enabled shift register used to align scan data with RAM read latency.
module delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  // Advance one stage per strobe; hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/pixel_fetch.sv
// Fetches a scaled image from RAM into a fixed screen window, frame-synchronised start.
module pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned WIN_X0 = WIN_X0_DEF,
  parameter int unsigned WIN_Y0 = WIN_Y0_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF,
  parameter int unsigned WIN_H  = WIN_H_DEF,
  parameter int unsigned SCALE  = SCALE_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        start,
  output logic        ram_rd,
  output logic [13:0] ram_addr,
  input  logic [23:0] ram_data,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out,
  output logic        active
);

  localparam int unsigned SubW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SubW-1:0] SubMax = SubW'(SCALE - 1);
  localparam logic [10:0] XLo   = 11'(WIN_X0);
  localparam logic [10:0] XHi   = 11'(WIN_X0 + WIN_W);
  localparam logic [10:0] YLo   = 11'(WIN_Y0);
  localparam logic [10:0] YHi   = 11'(WIN_Y0 + WIN_H);
  localparam logic [10:0] XLast = 11'(WIN_X0 + WIN_W - 1);
  localparam logic [10:0] YLast = 11'(WIN_Y0 + WIN_H - 1);
  localparam logic [13:0] RowStep = 14'(IMG_W);
  localparam int unsigned PipeW = 23;

  state_e           state_q;
  logic             start_pend_q;
  logic             active_q;
  logic [13:0]      col_q;
  logic [13:0]      row_base_q;
  logic [SubW-1:0]  col_sub_q;
  logic [SubW-1:0]  row_sub_q;

  logic [10:0]      xw;
  logic [10:0]      yw;
  logic             in_win;
  logic             origin;
  logic             rd;
  logic             last_col;
  logic             last_row;
  logic [PipeW-1:0] pipe_in;
  logic [PipeW-1:0] pipe_out;
  logic             valid_dly;
  rgb888_t          pixel;

  assign xw       = {1'b0, x};
  assign yw       = {1'b0, y};
  assign in_win   = (xw >= XLo) && (xw < XHi) && (yw >= YLo) && (yw < YHi);
  assign origin   = (x == 10'd0) && (y == 10'd0);
  assign rd       = pix_en && in_win && (state_q == StActive);
  assign last_col = (xw == XLast);
  assign last_row = (yw == YLast);

  // Start is captured on any clock but only acted on at a strobe; display begins at frame origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      start_pend_q <= 1'b0;
      active_q     <= 1'b0;
    end else if (pix_en) begin
      start_pend_q <= 1'b0;
      case (state_q)
        StIdle:   if (start || start_pend_q) state_q <= StArmed;
        StArmed:  begin
          if (origin) begin
            state_q  <= StActive;
            active_q <= 1'b1;
          end
        end
        StActive: state_q <= StActive;
        default:  begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
      endcase
    end else if (start && (state_q == StIdle)) begin
      start_pend_q <= 1'b1;
    end
  end

  // Multiplier-free address walk: column every SCALE reads, row base every SCALE lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      col_sub_q  <= '0;
      row_sub_q  <= '0;
      row_base_q <= '0;
    end else if (pix_en) begin
      if (origin) begin
        col_q      <= '0;
        col_sub_q  <= '0;
        row_sub_q  <= '0;
        row_base_q <= '0;
      end else if (rd) begin
        if (last_col) begin
          col_q     <= '0;
          col_sub_q <= '0;
          if (row_sub_q == SubMax) begin
            row_sub_q <= '0;
            // Wrap after the final image row so the address never exceeds the image.
            row_base_q <= last_row ? 14'd0 : row_base_q + RowStep;
          end else begin
            row_sub_q <= row_sub_q + SubW'(1);
          end
        end else if (col_sub_q == SubMax) begin
          col_sub_q <= '0;
          col_q     <= col_q + 14'd1;
        end else begin
          col_sub_q <= col_sub_q + SubW'(1);
        end
      end
    end
  end

  assign pipe_in = {x, y, hsync_in, vsync_in, rd};

  delay_line #(
    .Width (PipeW),
    .Depth (RD_LAT)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign x_out     = pipe_out[22:13];
  assign y_out     = pipe_out[12:3];
  assign hsync_out = pipe_out[2];
  assign vsync_out = pipe_out[1];
  assign valid_dly = pipe_out[0];

  assign pixel     = valid_dly ? ram_data : 24'h000000;
  assign pixel_out = pixel;
  assign ram_rd    = rd;
  assign ram_addr  = row_base_q + col_q;
  assign active    = active_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: full-size instance on a sparse raster, small instance on full frames.
module tb_pixel_fetch;

  localparam int AX0 = 120, AY0 = 40, AW = 400, AH = 400, AS = 4, AIW = 100;
  localparam int BX0 = 6, BY0 = 3, BW = 16, BH = 8, BS = 2, BIW = 8;
  localparam int BHT = 24, BVT = 14;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        v;
    logic [13:0] addr;
  } ent_t;

  typedef struct {
    int kind;  // 0: ram_addr at input (x,y); 1: pixel_out at (x_out,y_out)
    int xx;
    int yy;
    int exp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, pix_en = 1'b0, start = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic        rd [2];
  logic [13:0] addr [2];
  logic [23:0] rdat [2];
  logic [23:0] r1 [2];
  logic [23:0] pix [2];
  logic [9:0]  xo [2];
  logic [9:0]  yo [2];
  logic        hso [2];
  logic        vso [2];
  logic        act [2];

  int n_pass = 0, n_chk = 0;
  int mode = 0, pend = 0;  // mode: 0 idle, 1 armed, 2 active
  ent_t pipe [2][2];
  vec_t tbl [8];
  int got [8];
  bit rec = 0, seen0 = 0;
  int fx, fy, fa, acount, bcount, bmax;

  always #5 clk = ~clk;

  pixel_fetch u_a (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .hsync_in(hs), .vsync_in(vs),
    .start(start), .ram_rd(rd[0]), .ram_addr(addr[0]), .ram_data(rdat[0]), .x_out(xo[0]),
    .y_out(yo[0]), .hsync_out(hso[0]), .vsync_out(vso[0]), .pixel_out(pix[0]), .active(act[0])
  );

  pixel_fetch #(
    .WIN_X0(BX0), .WIN_Y0(BY0), .WIN_W(BW), .WIN_H(BH), .SCALE(BS), .IMG_W(BIW), .RD_LAT(2)
  ) u_b (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .hsync_in(hs), .vsync_in(vs),
    .start(start), .ram_rd(rd[1]), .ram_addr(addr[1]), .ram_data(rdat[1]), .x_out(xo[1]),
    .y_out(yo[1]), .hsync_out(hso[1]), .vsync_out(vso[1]), .pixel_out(pix[1]), .active(act[1])
  );

  function automatic logic [23:0] tag(logic [13:0] a);
    return {10'h2B3, a};
  endfunction

  // Two-strobe RAM returning address-tagged words; junk when not read so gating is visible.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        r1[d]   <= '0;
        rdat[d] <= '0;
      end else if (pix_en) begin
        r1[d]   <= rd[d] ? tag(addr[d]) : 24'hDEAD00;
        rdat[d] <= r1[d];
      end
    end
  end

  function automatic void chk(string nm, int d, longint act_v, longint exp_v);
    n_chk++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act_v, exp_v);
  endfunction

  function automatic bit inwin(int d, int xx, int yy);
    if (d == 0) return xx >= AX0 && xx < AX0 + AW && yy >= AY0 && yy < AY0 + AH;
    return xx >= BX0 && xx < BX0 + BW && yy >= BY0 && yy < BY0 + BH;
  endfunction

  // Image address of a window pixel, straight from the scaling rule.
  function automatic int eaddr(int d, int xx, int yy);
    if (d == 0) return ((yy - AY0) / AS) * AIW + (xx - AX0) / AS;
    return ((yy - BY0) / BS) * BIW + (xx - BX0) / BS;
  endfunction

  function automatic bit erd(int d);
    return pix_en && inwin(d, int'(x), int'(y)) && mode == 2;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit er;
      ent_t o;
      er = erd(d);
      o  = pipe[d][1];
      chk("ram_rd", d, rd[d], er);
      if (er) chk("ram_addr", d, addr[d], eaddr(d, int'(x), int'(y)));
      chk("x_out", d, xo[d], o.x);
      chk("y_out", d, yo[d], o.y);
      chk("hsync_out", d, hso[d], o.hs);
      chk("vsync_out", d, vso[d], o.vs);
      chk("pixel_out", d, pix[d], o.v ? tag(o.addr) : 24'h0);
      chk("active", d, act[d], mode == 2);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      mode = 0;
      pend = 0;
      for (int d = 0; d < 2; d++) begin
        pipe[d][0] = '0;
        pipe[d][1] = '0;
      end
    end else if (pix_en) begin
      for (int d = 0; d < 2; d++) begin
        ent_t e;
        e.x = x; e.y = y; e.hs = hs; e.vs = vs;
        e.v = erd(d);
        e.addr = e.v ? 14'(eaddr(d, int'(x), int'(y))) : 14'd0;
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = e;
      end
      if (mode == 0 && (start || pend != 0)) mode = 1;
      else if (mode == 1 && x == 10'd0 && y == 10'd0) mode = 2;
      pend = 0;
    end else if (start && mode == 0) begin
      pend = 1;
    end
  endtask

  task automatic record();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].kind == 0 && pix_en && int'(x) == tbl[i].xx && int'(y) == tbl[i].yy)
        got[i] = rd[0] ? int'(addr[0]) : -1;
      else if (tbl[i].kind == 1 && int'(xo[0]) == tbl[i].xx && int'(yo[0]) == tbl[i].yy)
        got[i] = int'(pix[0]);
    end
  endtask

  // One clock: check before the edge, then advance the model with the edge's inputs.
  task automatic cyc(bit en, bit st, bit rst);
    pix_en = en; start = st; reset = rst;
    @(negedge clk);
    check_all();
    if (pix_en && rd[0]) begin
      acount++;
      if (!seen0) begin
        seen0 = 1; fx = int'(x); fy = int'(y); fa = int'(addr[0]);
      end
    end
    if (pix_en && rd[1]) begin
      bcount++;
      if (int'(addr[1]) > bmax) bmax = int'(addr[1]);
    end
    if (rec) record();
    @(posedge clk);
    #1;
    model_edge();
    pix_en = 1'b0; start = 1'b0; reset = 1'b0;
  endtask

  task automatic strobe(int xx, int yy, bit st, bit rst);
    x = 10'(xx); y = 10'(yy); hs = 1'($urandom); vs = 1'($urandom);
    cyc(1'b1, st, rst);
  endtask

  // Sparse raster for the full-size window: origin column, window edges and a sync column.
  task automatic a_lines(int y0, int y1);
    for (int yy = y0; yy <= y1; yy++) begin
      strobe(0, yy, 1'b0, 1'b0);
      strobe(119, yy, 1'b0, 1'b0);
      for (int xx = 120; xx <= 520; xx++) strobe(xx, yy, 1'b0, 1'b0);
      strobe(700, yy, 1'b0, 1'b0);
    end
  endtask

  // Full small-raster frame with random strobe gaps; start pulsed at strobe index st_at.
  task automatic b_frame(int st_at);
    int idx, exp_n, g;
    idx = 0;
    exp_n = (mode != 0) ? BW * BH : 0;
    bcount = 0; bmax = 0;
    for (int yy = 0; yy < BVT; yy++) begin
      for (int xx = 0; xx < BHT; xx++) begin
        g = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
        repeat (g) cyc(1'b0, 1'b0, 1'b0);
        strobe(xx, yy, idx == st_at, 1'b0);
        idx++;
      end
    end
    chk("frame_reads", 1, bcount, exp_n);
    if (exp_n != 0) chk("last_addr", 1, bmax, BIW * (BH / BS) - 1);
  endtask

  initial begin
    tbl[0] = '{0, 120, 40, 0};
    tbl[1] = '{0, 123, 40, 0};
    tbl[2] = '{0, 124, 40, 1};
    tbl[3] = '{0, 519, 43, 99};
    tbl[4] = '{0, 120, 44, 100};
    tbl[5] = '{1, 124, 44, int'({10'h2B3, 14'd101})};
    tbl[6] = '{1, 119, 44, 0};
    tbl[7] = '{1, 520, 44, 0};
    for (int i = 0; i < 8; i++) got[i] = -2;

    // Reset, then idle / armed / active frames on the small instance.
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    b_frame(-1);
    b_frame(100);
    b_frame(-1);
    b_frame(-1);

    // Mid-frame start, activation at origin, address walk on the full-size window.
    x = 10'd0; y = 10'd0;
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    seen0 = 0; fa = -1;
    strobe(300, 200, 1'b1, 1'b0);
    strobe(301, 200, 1'b0, 1'b0);
    rec = 1;
    a_lines(0, 45);
    rec = 0;
    for (int i = 0; i < 8; i++) chk($sformatf("vec%0d", i), 0, got[i], tbl[i].exp);
    chk("first_rd_x", 0, fx, 120);
    chk("first_rd_y", 0, fy, 40);
    chk("first_rd_addr", 0, fa, 0);

    // Reset while active, restart mid-frame: nothing until the next origin.
    x = 10'd300; y = 10'd200;
    cyc(1'b0, 1'b0, 1'b1);
    strobe(0, 10, 1'b1, 1'b0);
    acount = 0;
    a_lines(40, 41);
    chk("reads_before_origin", 0, acount, 0);
    seen0 = 0; fa = -1;
    a_lines(0, 0);
    a_lines(40, 40);
    chk("restart_addr", 0, fa, 0);
    chk("restart_x", 0, fx, 120);

    // Strobe gap while active: counters hold.
    strobe(120, 41, 1'b0, 1'b0);
    strobe(121, 41, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    strobe(122, 41, 1'b0, 1'b0);
    strobe(123, 41, 1'b0, 1'b0);
    strobe(124, 41, 1'b0, 1'b0);

    // Start pulsed in a strobe gap is remembered.
    x = 10'd60; y = 10'd5;
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    strobe(60, 5, 1'b0, 1'b0);
    strobe(61, 5, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    strobe(62, 5, 1'b0, 1'b0);
    strobe(63, 5, 1'b0, 1'b0);
    strobe(0, 0, 1'b0, 1'b0);
    strobe(1, 0, 1'b0, 1'b0);
    chk("gap_start_active", 0, act[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameters, one per line, as name, default, meaning:
- WIN_X0, 120, first window column.
- WIN_Y0, 40, first window row.
- WIN_W, 400, window width in screen pixels.
- WIN_H, 400, window height in screen pixels.
- SCALE, 4, pixel replication factor, power of two.
- IMG_W, 100, source image width (WIN_W/SCALE).
- RD_LAT, 2, RAM read latency in pix_en strobes.

REQ-002 Ports, one per line, as name, direction, width, meaning:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pix_en  in  1  pixel-rate strobe; all state advances only when high.
- x  in  10  current scan column (0..799).
- y  in  10  current scan row (0..524).
- hsync_in  in  1  horizontal sync, timing-aligned with x/y.
- vsync_in  in  1  vertical sync, timing-aligned with x/y.
- start  in  1  single-cycle request to begin display.
- ram_rd  out  1  read strobe to image RAM.
- ram_addr  out  14  image RAM word address.
- ram_data  in  24  RGB888 word, valid RD_LAT strobes after ram_rd.
- x_out  out  10  x delayed RD_LAT strobes.
- y_out  out  10  y delayed RD_LAT strobes.
- hsync_out  out  1  hsync delayed RD_LAT strobes.
- vsync_out  out  1  vsync delayed RD_LAT strobes.
- pixel_out  out  24  RGB888 aligned with x_out/y_out.
- active  out  1  high while in ACTIVE state.

Function
REQ-003 FSM states: IDLE, ARMED, ACTIVE; evaluated on pix_en only, except start.
REQ-004 IDLE->ARMED on start=1; start is sampled on any clk edge and held pending until the next pix_en.
REQ-005 ARMED->ACTIVE on the pix_en at which x==0 && y==0 (frame origin); mid-frame start never produces a partial frame.
REQ-006 start in ARMED or ACTIVE is ignored; ACTIVE persists until reset.
REQ-007 in_win = (WIN_X0 <= x < WIN_X0+WIN_W) && (WIN_Y0 <= y < WIN_Y0+WIN_H); both bounds half-open, exactly 400x400 pixels.
REQ-008 ram_rd = pix_en && in_win && state==ACTIVE; in IDLE/ARMED, ram_rd=0.
REQ-009 Address formed without multiplier: ram_addr = row_base + col.
- col: 0..IMG_W-1, increments every SCALE in-window pixels.
- row_base: increments by IMG_W every SCALE window lines.
REQ-010 col and column sub-counter clear after the pixel at x==WIN_X0+WIN_W-1.
REQ-011 Row sub-counter increments at that same pixel; on wrap to 0, row_base += IMG_W.
REQ-012 All address counters clear at frame origin (x==0 && y==0); last window address is 9999, never exceeded.
REQ-013 x, y, hsync, vsync and the gated in_win flag pass through a RD_LAT-deep pipeline advanced by pix_en; outputs stay stable between strobes.
REQ-014 pixel_out = ram_data when the delayed gated in_win flag is 1, else 24'h000000.
REQ-015 Latency: total of exactly RD_LAT pix_en strobes from x/y input to x_out/y_out/pixel_out.
REQ-016 Sync outputs are passed through in every state, so the display stays locked while IDLE.

Reset
REQ-017 reset dominates start and pix_en on the same edge.
REQ-018 On reset:
- FSM returns to IDLE.
- All counters and pipeline stages clear to 0.
- pixel_out=0, ram_rd=0, ram_addr=0, active=0.
- x_out=0, y_out=0, hsync_out=0, vsync_out=0.
- Any pending start is dropped.
REQ-019 reset mid-frame aborts immediately; the first valid data after reset requires a new start followed by a frame origin.

Structure
REQ-020 Shared package vga_pkg holds:
- The state enum.
- Window/scale constants.
- The 640x480 timing constants (H_TOTAL=800, V_TOTAL=525).
- The rgb888_t typedef.
REQ-021 Sub-module delay_line (parameterised width and depth, pix_en-enabled) implements the REQ-013 pipeline; FSM and address counters are local.

Verification
REQ-022 Reset, no start, full frame -> ram_rd never asserted; pixel_out==0 throughout; sync outputs track inputs delayed by 2.
REQ-023 start at x=300,y=200 -> state ARMED until (0,0), then ACTIVE; first ram_rd at (120,40) with ram_addr=0.
REQ-024 ACTIVE frame -> check ram_addr at these coordinates:
- (123,40)=0.
- (124,40)=1.
- (519,43)=99.
- (120,44)=100.
- (519,439)=9999.
- Exactly 160000 reads per frame.
REQ-025 RAM model returning addr-tagged data -> pixel_out at x_out=124,y_out=44 equals data for addr 101; pixel_out==0 at x_out=119 and x_out=520.
REQ-026 reset asserted at (300,200) in ACTIVE, released, start at (0,10) -> no reads until the following frame origin; addresses restart at 0.
REQ-027 pix_en low for 3 clocks mid-line -> all outputs and counters hold; start pulsed during the gap is honoured at the next strobe.
